// File: rtl/ofu_pkg.sv
// ofu_pkg: widths and types shared by the operand fetch unit and the
// register-bank / issue-side logic around it.
// The optional forwarding feature is selected by the OFU_BYPASS_EN macro.
package ofu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    // One operand-fetch request as it sits in the read-pending stage.
    typedef struct packed {
        reg_idx_t src1;
        reg_idx_t src2;
        reg_idx_t dst;
    } fetch_req_t;

    // True when a writeback this cycle targets the given register index.
    function automatic logic wbHits(input logic wbValid,
                                    input reg_idx_t wbAddr,
                                    input reg_idx_t idx);
        return wbValid && (wbAddr == idx);
    endfunction

endpackage

// File: rtl/ofu_bypass_mux.sv
// ofu_bypass_mux: per-operand writeback forwarding for the operand fetch unit.
// With OFU_BYPASS_EN defined it holds a bypass register that remembers a
// writeback landing on the edge the bank sampled the read, and selects
// between the live writeback, that remembered value and the bank data.
// Without OFU_BYPASS_EN it simply passes the bank data through.
module ofu_bypass_mux import ofu_pkg::*; (
`ifdef OFU_BYPASS_EN
    input  logic     clk,
    input  logic     rst,
    input  logic     capture_i,
    input  reg_idx_t read_idx_i,
    input  reg_idx_t hold_idx_i,
    input  logic     wb_valid_i,
    input  reg_idx_t wb_addr_i,
    input  word_t    wb_data_i,
`endif
    input  word_t    rf_rdata_i,
    output word_t    operand_o
);

`ifdef OFU_BYPASS_EN
    logic  bypValid_q;
    logic  bypValid_d;
    word_t bypData_q;
    word_t bypData_d;

    // Re-arm the bypass on every edge the bank samples this operand's index,
    // so it tracks a write that the bank read would otherwise miss.
    always_comb begin
        bypValid_d = bypValid_q;
        bypData_d  = bypData_q;
        if (capture_i) begin
            bypValid_d = wbHits(wb_valid_i, wb_addr_i, read_idx_i);
            bypData_d  = wb_data_i;
        end
    end

    // Bypass register; cleared by reset so a dropped request leaves no trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bypValid_q <= 1'b0;
            bypData_q  <= '0;
        end else begin
            bypValid_q <= bypValid_d;
            bypData_q  <= bypData_d;
        end
    end

    // Newest value wins: live writeback, then sample-edge write, then bank.
    always_comb begin
        operand_o = rf_rdata_i;
        if (wbHits(wb_valid_i, wb_addr_i, hold_idx_i)) begin
            operand_o = wb_data_i;
        end else if (bypValid_q) begin
            operand_o = bypData_q;
        end
    end
`else
    // No forwarding: the operand is whatever the bank returned.
    assign operand_o = rf_rdata_i;
`endif

endmodule

// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit: requester-side front end for the 8x16 register bank.
// Stage R waits out the bank's registered read, stage O presents both
// operands on a valid/ready interface. Writebacks pass straight through to
// the bank write port. Forwarding is enabled by defining OFU_BYPASS_EN.
module operand_fetch_unit import ofu_pkg::*; (
    input  logic     clk,
    input  logic     rst,
    input  logic     req_valid_i,
    output logic     req_ready_o,
    input  reg_idx_t req_src1_i,
    input  reg_idx_t req_src2_i,
    input  reg_idx_t req_dst_i,
    input  logic     wb_valid_i,
    input  reg_idx_t wb_addr_i,
    input  word_t    wb_data_i,
    output reg_idx_t rf_raddr1_o,
    output reg_idx_t rf_raddr2_o,
    input  word_t    rf_rdata1_i,
    input  word_t    rf_rdata2_i,
    output logic     rf_wen_o,
    output reg_idx_t rf_waddr_o,
    output word_t    rf_wdata_o,
    output logic     op_valid_o,
    input  logic     op_ready_i,
    output word_t    op_a_o,
    output word_t    op_b_o,
    output reg_idx_t op_dst_o
);

    logic       rValid_q;
    logic       rValid_d;
    fetch_req_t rReq_q;
    fetch_req_t rReq_d;

    logic       opValid_q;
    logic       opValid_d;
    word_t      opA_q;
    word_t      opA_d;
    word_t      opB_q;
    word_t      opB_d;
    reg_idx_t   opDst_q;
    reg_idx_t   opDst_d;

    logic       rAdv;
    logic       rStall;
    logic       accept;
    word_t      operand1;
    word_t      operand2;

    // R moves into O whenever O is empty or being drained this cycle.
    assign rAdv        = rValid_q && (!opValid_q || op_ready_i);
    assign rStall      = rValid_q && !rAdv;
    assign req_ready_o = !rValid_q || rAdv;
    assign accept      = req_valid_i && req_ready_o;

    // A stalled R keeps presenting its own indices so the bank keeps re-reading them.
    assign rf_raddr1_o = rStall ? rReq_q.src1 : req_src1_i;
    assign rf_raddr2_o = rStall ? rReq_q.src2 : req_src2_i;

    assign rf_wen_o    = wb_valid_i;
    assign rf_waddr_o  = wb_addr_i;
    assign rf_wdata_o  = wb_data_i;

    assign op_valid_o  = opValid_q;
    assign op_a_o      = opA_q;
    assign op_b_o      = opB_q;
    assign op_dst_o    = opDst_q;

`ifdef OFU_BYPASS_EN
    logic capture;

    assign capture = accept || rStall;

    ofu_bypass_mux uBypass1 (
        .clk        (clk),
        .rst        (rst),
        .capture_i  (capture),
        .read_idx_i (rf_raddr1_o),
        .hold_idx_i (rReq_q.src1),
        .wb_valid_i (wb_valid_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .rf_rdata_i (rf_rdata1_i),
        .operand_o  (operand1)
    );

    ofu_bypass_mux uBypass2 (
        .clk        (clk),
        .rst        (rst),
        .capture_i  (capture),
        .read_idx_i (rf_raddr2_o),
        .hold_idx_i (rReq_q.src2),
        .wb_valid_i (wb_valid_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .rf_rdata_i (rf_rdata2_i),
        .operand_o  (operand2)
    );
`else
    ofu_bypass_mux uBypass1 (
        .rf_rdata_i (rf_rdata1_i),
        .operand_o  (operand1)
    );

    ofu_bypass_mux uBypass2 (
        .rf_rdata_i (rf_rdata2_i),
        .operand_o  (operand2)
    );
`endif

    // R next state: load on accept, otherwise empty out when it advances.
    always_comb begin
        rValid_d = rValid_q;
        rReq_d   = rReq_q;
        if (accept) begin
            rValid_d    = 1'b1;
            rReq_d.src1 = req_src1_i;
            rReq_d.src2 = req_src2_i;
            rReq_d.dst  = req_dst_i;
        end else if (rAdv) begin
            rValid_d = 1'b0;
        end
    end

    // O next state: capture operands as R advances, drop after handshake, else freeze.
    always_comb begin
        opValid_d = opValid_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        opDst_d   = opDst_q;
        if (rAdv) begin
            opValid_d = 1'b1;
            opA_d     = operand1;
            opB_d     = operand2;
            opDst_d   = rReq_q.dst;
        end else if (op_ready_i) begin
            opValid_d = 1'b0;
        end
    end

    // Pipeline registers; reset drops any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rValid_q  <= 1'b0;
            rReq_q    <= '0;
            opValid_q <= 1'b0;
            opA_q     <= '0;
            opB_q     <= '0;
            opDst_q   <= '0;
        end else begin
            rValid_q  <= rValid_d;
            rReq_q    <= rReq_d;
            opValid_q <= opValid_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            opDst_q   <= opDst_d;
        end
    end

endmodule
